// File: rtl/prf_pkg.sv
// Shared defaults and tag-width derivation for the 2-read / 2-write physical register file.
// Optional same-cycle write-to-read forwarding is enabled by defining PRF_BYPASS_EN.
package prf_pkg;

   localparam int PRF_DATA_WIDTH = 32;
   localparam int PRF_DEPTH      = 64;

   function automatic int tag_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/prf_read_port.sv
// One combinational read port: entry select, hardwired tag 0, enable gating, optional forwarding.
// Forwarding from the write ports is compiled in only when PRF_BYPASS_EN is defined.
module prf_read_port
   import prf_pkg::*;
#(
   parameter int DATA_WIDTH = PRF_DATA_WIDTH,
   parameter int DEPTH      = PRF_DEPTH,
   parameter int TAG_WIDTH  = tag_width(DEPTH)
) (
   input  logic                  rd_en_i,
   input  logic [TAG_WIDTH-1:0]  rd_tag_i,
   input  logic [DATA_WIDTH-1:0] entries_i [DEPTH],
   input  logic [DEPTH-1:0]      ready_i,
`ifdef PRF_BYPASS_EN
   input  logic                  byp1_en_i,
   input  logic [TAG_WIDTH-1:0]  byp1_tag_i,
   input  logic [DATA_WIDTH-1:0] byp1_data_i,
   input  logic                  byp2_en_i,
   input  logic [TAG_WIDTH-1:0]  byp2_tag_i,
   input  logic [DATA_WIDTH-1:0] byp2_data_i,
`endif
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  ready_o
);

   always_comb begin
      data_o  = '0;
      ready_o = 1'b0;
      if (rd_en_i) begin
         if (rd_tag_i == '0) begin
            data_o  = '0;
            ready_o = 1'b1;
         end
`ifdef PRF_BYPASS_EN
         // Bypass enables arrive pre-qualified: nonzero tag and not in reset.
         else if (byp1_en_i && (byp1_tag_i == rd_tag_i)) begin
            data_o  = byp1_data_i;
            ready_o = 1'b1;
         end
         else if (byp2_en_i && (byp2_tag_i == rd_tag_i)) begin
            data_o  = byp2_data_i;
            ready_o = 1'b1;
         end
`endif
         else begin
            data_o  = entries_i[rd_tag_i];
            ready_o = ready_i[rd_tag_i];
         end
      end
   end

endmodule

// File: rtl/prf_2r_2w.sv
// Physical register file: DEPTH entries with a ready bit each, two write ports, two read ports.
// Define PRF_BYPASS_EN to forward same-cycle write data to matching reads.
module prf_2r_2w
   import prf_pkg::*;
#(
   parameter int DATA_WIDTH = PRF_DATA_WIDTH,
   parameter int DEPTH      = PRF_DEPTH,
   localparam int TAG_WIDTH = tag_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alloc_en_i,
   input  logic [TAG_WIDTH-1:0]  alloc_tag_i,
   input  logic                  write1_en_i,
   input  logic [TAG_WIDTH-1:0]  write1_tag_i,
   input  logic [DATA_WIDTH-1:0] data1_i,
   input  logic                  write2_en_i,
   input  logic [TAG_WIDTH-1:0]  write2_tag_i,
   input  logic [DATA_WIDTH-1:0] data2_i,
   input  logic                  read1_en_i,
   input  logic [TAG_WIDTH-1:0]  read1_tag_i,
   output logic [DATA_WIDTH-1:0] data1_o,
   output logic                  ready1_o,
   input  logic                  read2_en_i,
   input  logic [TAG_WIDTH-1:0]  read2_tag_i,
   output logic [DATA_WIDTH-1:0] data2_o,
   output logic                  ready2_o
);

   generate
      if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
         $error("prf_2r_2w: DEPTH must be a power of two and at least 2");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] r_data [DEPTH];
   logic [DEPTH-1:0]      r_ready;

   // Entry 0 is never written after reset, so it holds zero / ready permanently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i] <= '0;
         end
         r_ready <= '1;
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (write1_en_i && (write1_tag_i == TAG_WIDTH'(i))) begin
               r_data[i] <= data1_i;
            end else if (write2_en_i && (write2_tag_i == TAG_WIDTH'(i))) begin
               r_data[i] <= data2_i;
            end
            if (alloc_en_i && (alloc_tag_i == TAG_WIDTH'(i))) begin
               r_ready[i] <= 1'b0;
            end else if ((write1_en_i && (write1_tag_i == TAG_WIDTH'(i))) ||
                         (write2_en_i && (write2_tag_i == TAG_WIDTH'(i)))) begin
               r_ready[i] <= 1'b1;
            end
         end
      end
   end

`ifdef PRF_BYPASS_EN
   logic w_byp1_en;
   logic w_byp2_en;

   assign w_byp1_en = write1_en_i && !rst && (write1_tag_i != '0);
   assign w_byp2_en = write2_en_i && !rst && (write2_tag_i != '0);
`endif

   prf_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .TAG_WIDTH  (TAG_WIDTH)
   ) u_read1 (
      .rd_en_i     (read1_en_i),
      .rd_tag_i    (read1_tag_i),
      .entries_i   (r_data),
      .ready_i     (r_ready),
`ifdef PRF_BYPASS_EN
      .byp1_en_i   (w_byp1_en),
      .byp1_tag_i  (write1_tag_i),
      .byp1_data_i (data1_i),
      .byp2_en_i   (w_byp2_en),
      .byp2_tag_i  (write2_tag_i),
      .byp2_data_i (data2_i),
`endif
      .data_o      (data1_o),
      .ready_o     (ready1_o)
   );

   prf_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .TAG_WIDTH  (TAG_WIDTH)
   ) u_read2 (
      .rd_en_i     (read2_en_i),
      .rd_tag_i    (read2_tag_i),
      .entries_i   (r_data),
      .ready_i     (r_ready),
`ifdef PRF_BYPASS_EN
      .byp1_en_i   (w_byp1_en),
      .byp1_tag_i  (write1_tag_i),
      .byp1_data_i (data1_i),
      .byp2_en_i   (w_byp2_en),
      .byp2_tag_i  (write2_tag_i),
      .byp2_data_i (data2_i),
`endif
      .data_o      (data2_o),
      .ready_o     (ready2_o)
   );

endmodule

// File: doc/prf_2r_2w.md
PRF_2R_2W -- requirements
Module: prf_2r_2w

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the entry width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, meaning the entry count; must be a power of two and at least 2.
REQ-003 SHALL derive localparam TAG_WIDTH = clog2(DEPTH).
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-006 SHALL have port alloc_en_i, input, 1, which clears the ready bit of alloc_tag_i.
REQ-007 SHALL have port alloc_tag_i, input, TAG_WIDTH, the entry being allocated.
REQ-008 SHALL have ports write1_en_i / write2_en_i, input, 1 each, the write strobes.
REQ-009 SHALL have ports write1_tag_i / write2_tag_i, input, TAG_WIDTH each, the write addresses.
REQ-010 SHALL have ports data1_i / data2_i, input, DATA_WIDTH each, the write data.
REQ-011 SHALL have ports read1_en_i / read2_en_i, input, 1 each, the read strobes.
REQ-012 SHALL have ports read1_tag_i / read2_tag_i, input, TAG_WIDTH each, the read addresses.
REQ-013 SHALL have ports data1_o / data2_o, output, DATA_WIDTH each, the read data.
REQ-014 SHALL have ports ready1_o / ready2_o, output, 1 each, the read entry's ready bit.

Function
REQ-015 SHALL store DEPTH entries of DATA_WIDTH bits plus one ready bit per entry.
REQ-016 SHALL perform writes on the rising clk edge; both ports may commit in one cycle to different tags.
REQ-017 SHALL, when both write ports are enabled with the same tag, commit data1_i only (write1 priority).
REQ-018 SHALL set the ready bit of each written tag on the same edge as the data write.
REQ-019 SHALL clear the ready bit of alloc_tag_i on the edge where alloc_en_i=1, leaving the entry data unchanged.
REQ-020 SHALL, when alloc and write target the same tag in one cycle, leave ready=0 (alloc wins) and still commit the data.
REQ-021 SHALL hardwire entry 0: reads return 0 with ready=1, and writes and allocs to tag 0 are ignored.
REQ-022 SHALL make reads combinational; read_en=1 returns the entry data and ready bit with zero latency.
REQ-023 SHALL, with read_en=0, drive data_o=0 and ready_o=0.
REQ-024 SHALL keep the two read ports fully independent; both ports may read the same tag simultaneously.

Reset
REQ-025 SHALL, while rst=1, force all entries to 0 and all ready bits to 1 asynchronously, and ignore writes and allocs.
REQ-026 SHALL make read outputs reflect the reset state combinationally during reset: data 0, ready 1 when enabled.
REQ-027 SHALL discard a write or alloc coincident with the reset assertion edge.

Configuration
REQ-028 SHALL, with macro PRF_BYPASS_EN defined, forward same-cycle write data to a read whose tag matches an enabled nonzero write tag, with write1 priority and ready_o=1.
REQ-029 SHALL, with PRF_BYPASS_EN undefined, read only stored state, so written data becomes visible the cycle after the write.

Structure
REQ-030 SHALL place the default DATA_WIDTH, the default DEPTH and the TAG_WIDTH derivation in shared package prf_pkg.
REQ-031 SHALL instantiate sub-module prf_read_port once per read port; it performs entry select, the tag-0 rule, read-enable gating and optional bypass.

Verification
REQ-032 Reset check: assert rst mid-run, then read tag 5 -> data 0, ready 1.
REQ-033 Dual write: write1 tag 3 = 0xAAAA0001 and write2 tag 7 = 0x5555_0002; next cycle read1 tag 3, read2 tag 7 -> both values, ready 1.
REQ-034 Write conflict: write1 and write2 both to tag 9 with 0x11 and 0x22 -> tag 9 reads 0x11.
REQ-035 Alloc vs write: alloc tag 4 while writing 0x44 to tag 4 -> next cycle data 0x44, ready 0; a later write sets ready 1.
REQ-036 Tag 0: write 0xFFFF to tag 0 -> read tag 0 gives 0, ready 1; alloc tag 0 -> ready stays 1.
REQ-037 Bypass: write1 tag 12 = 0xBEEF while read1 tag 12 in the same cycle -> 0xBEEF, ready 1 with PRF_BYPASS_EN; old data and old ready without it.
